srl32_fifo_ctrl: RTL and testbench

- Sequences a bank of SRLC32E shift registers so that they act as a 2-bit-wide (by default), 32-deep FIFO with valid/ready handshakes on both sides.
- All lanes share one CLK, CE and 5-bit A, as in the two-lane SRL32 minitest.
- The controller owns the occupancy counter, the shared CE/A drive and a registered output stage.
- Serves as the minitest/fuzzer block for dynamic-address SRL read behaviour under real traffic.

---
 rtl/srl_ctrl_pkg.sv | 16 +
 rtl/srl32_lane.sv | 22 ++
 rtl/srl32_fifo_ctrl.sv | 72 +++++++
 tb/tb_srl32_fifo_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/srl_ctrl_pkg.sv
// Shared constants and address helper for the SRLC32E-based FIFO controller.
// The oldest entry always sits at tap cnt-1 of every lane.
package srl_ctrl_pkg;

   localparam int SRL_MAX_DEPTH = 32;
   localparam int SRL_ADDR_W    = 5;
   localparam int LEVEL_W       = 6;

   // An empty SRL reads tap 0; the value is ignored because no load happens.
   function automatic logic [SRL_ADDR_W-1:0] oldest_addr(input logic [LEVEL_W-1:0] cnt);
      if (cnt == '0)
         return '0;
      return SRL_ADDR_W'(cnt - LEVEL_W'(1));
   endfunction

endpackage

// File: rtl/srl32_lane.sv
// Behavioural SRLC32E: 32-tap shift register with clock enable and a
// combinational dynamic-address read tap. Contents are never reset.
module srl32_lane
   import srl_ctrl_pkg::*;
(
   input  logic                  CLK,
   input  logic                  CE,
   input  logic                  D,
   input  logic [SRL_ADDR_W-1:0] A,
   output logic                  Q
);

   logic [SRL_MAX_DEPTH-1:0] sr;

   always_ff @(posedge CLK) begin
      if (CE)
         sr <= {sr[SRL_MAX_DEPTH-2:0], D};
   end

   assign Q = sr[A];

endmodule

// File: rtl/srl32_fifo_ctrl.sv
// FIFO controller over WIDTH SRLC32E lanes sharing CE and A, with a
// registered output stage and valid/ready handshakes on both sides.
module srl32_fifo_ctrl
   import srl_ctrl_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DEPTH = 32
)
(
   input  logic               CLK,
   input  logic               RST,
   input  logic [WIDTH-1:0]   IN_DATA,
   input  logic               IN_VALID,
   output logic               IN_READY,
   output logic [WIDTH-1:0]   OUT_DATA,
   output logic               OUT_VALID,
   input  logic               OUT_READY,
   input  logic               FLUSH,
   output logic [LEVEL_W-1:0] LEVEL
);

   logic [LEVEL_W-1:0]    cnt;
   logic                  ov;
   logic [WIDTH-1:0]      od;
   logic                  push;
   logic                  pop;
   logic                  load;
   logic [SRL_ADDR_W-1:0] srl_a;
   logic [WIDTH-1:0]      srl_q;

   // Write side: SRL shifts only on an accepted word
   assign IN_READY = !RST && !FLUSH && (cnt < LEVEL_W'(DEPTH));
   assign push     = IN_VALID && IN_READY;
   assign pop      = ov && OUT_READY;
   assign load     = (cnt != '0) && (!ov || pop);
   assign srl_a    = oldest_addr(cnt);

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      srl32_lane u_lane (
         .CLK (CLK),
         .CE  (push),
         .D   (IN_DATA[i]),
         .A   (srl_a),
         .Q   (srl_q[i])
      );
   end

   // Occupancy and output stage; Q is sampled before a simultaneous shift lands
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt <= '0;
         ov  <= 1'b0;
         od  <= '0;
      end else if (FLUSH) begin
         cnt <= '0;
         ov  <= 1'b0;
      end else begin
         cnt <= cnt + LEVEL_W'(push) - LEVEL_W'(load);
         if (load) begin
            od <= srl_q;
            ov <= 1'b1;
         end else if (pop) begin
            ov <= 1'b0;
         end
      end
   end

   assign OUT_DATA  = od;
   assign OUT_VALID = ov;
   assign LEVEL     = cnt + LEVEL_W'(ov);

endmodule

// File: tb/tb_srl32_fifo_ctrl.sv
// Scoreboard bench for srl32_fifo_ctrl: a queue of held words, each tagged
// with its accept cycle, predicts LEVEL, OUT_VALID, IN_READY and read data.
module tb_srl32_fifo_ctrl;

   localparam int W = 2;
   localparam int D = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic         flush = 1'b0;
   logic [5:0]   level;

   srl32_fifo_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
      .CLK       (clk),
      .RST       (rst),
      .IN_DATA   (in_data),
      .IN_VALID  (in_valid),
      .IN_READY  (in_ready),
      .OUT_DATA  (out_data),
      .OUT_VALID (out_valid),
      .OUT_READY (out_ready),
      .FLUSH     (flush),
      .LEVEL     (level)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] d;
      int           t;
   } ent_t;

   ent_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   n_acc = 0;
   int   n_pop = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // A word is visible at the output from two cycles after acceptance onward,
   // once everything older has been consumed.
   bit exp_v;
   bit exp_rdy;
   int cntm;
   always @(negedge clk) begin
      exp_v   = (q.size() > 0) && (q[0].t + 2 <= cyc);
      cntm    = q.size() - int'(exp_v);
      exp_rdy = !rst && !flush && (cntm < D);
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      chk("level", 32'(level), 32'(q.size()));
      if (rst || flush) begin
         q.delete();
      end else begin
         if (exp_v && out_ready) begin
            chk("out_data", 32'(out_data), 32'(q[0].d));
            void'(q.pop_front());
            n_pop++;
         end
         if (in_valid && exp_rdy) begin
            q.push_back('{d: in_data, t: cyc});
            n_acc++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 100 && level != 0; k++) step();
      chk(name, 32'(level), 32'd0);
   endtask

   int a0;
   int p0;

   initial begin
      // Reset with a writer already trying to push
      rst = 1'b1; in_valid = 1'b1; in_data = 2'b11;
      repeat (3) step();
      rst = 1'b0; in_valid = 1'b0;
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_acc", 32'(n_acc), 32'd0);

      // Single word through an idle FIFO
      in_valid = 1'b1; in_data = 2'b10; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("single_lvl_t1", 32'(level), 32'd1);
      chk("single_ov_t1", 32'(out_valid), 32'd0);
      step();
      chk("single_ov_t2", 32'(out_valid), 32'd1);
      chk("single_od_t2", 32'(out_data), 32'h2);
      chk("single_lvl_t2", 32'(level), 32'd1);
      step();
      chk("single_lvl_t3", 32'(level), 32'd0);

      // Fill to full with the reader stalled, then drain in order
      out_ready = 1'b0;
      a0 = n_acc;
      for (int i = 0; i < 40; i++) begin
         in_valid = 1'b1;
         in_data  = W'(i % 4);
         step();
      end
      in_valid = 1'b0;
      chk("full_accepts", 32'(n_acc - a0), 32'd33);
      chk("full_level", 32'(level), 32'd33);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      drain("full_drain");

      // Continuous streaming: one word per cycle after two cycles of latency
      p0 = n_pop;
      for (int i = 0; i < 200; i++) begin
         in_valid  = 1'b1;
         out_ready = 1'b1;
         in_data   = W'($urandom);
         step();
      end
      chk("stream_pops", 32'(n_pop - p0), 32'd198);
      chk("stream_level", 32'(level), 32'd2);
      drain("stream_drain");

      // Random handshakes on both sides
      for (int i = 0; i < 5000; i++) begin
         in_valid  = 1'($urandom);
         out_ready = 1'($urandom);
         in_data   = W'($urandom);
         step();
      end
      drain("random_drain");

      // Flush with 17 words held; the flushed words never come back
      out_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         in_valid = 1'b1;
         in_data  = 2'b11;
         step();
      end
      chk("flush_pre_level", 32'(level), 32'd17);
      flush = 1'b1; in_valid = 1'b1; in_data = 2'b11;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_level", 32'(level), 32'd0);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      p0 = n_pop;
      for (int i = 0; i < 5; i++) begin
         in_valid  = 1'b1;
         out_ready = 1'b1;
         in_data   = 2'b01;
         step();
      end
      drain("flush_drain");
      chk("flush_post_pops", 32'(n_pop - p0), 32'd5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
